// File: rtl/mod_mul_fold_2957.sv
// mod_mul_fold_2957: two-stage pipelined modular-multiply front end for Q = 2957.
// Stage 1 registers the 24-bit product a*b. Stage 2 registers that product
// folded by 0, K or 2K (K = Q << FOLD_SHIFT). The 23-bit result stays
// congruent to a*b mod Q and feeds the downstream Barrett reducer.
// Optional build macro MOD_MUL_RANGE_CHECK_EN adds the err / err_sticky
// outputs. They flag operands that are not reduced residues (a >= Q or b >= Q).
module mod_mul_fold_2957 #(
  parameter int Q          = 2957,
  parameter int FOLD_SHIFT = 11,
  parameter int OUT_W      = 23
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [11:0]      a,
  input  logic [11:0]      b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] dout
`ifdef MOD_MUL_RANGE_CHECK_EN
  ,
  output logic             err,
  output logic             err_sticky
`endif
);

  localparam logic [23:0] K   = 24'(Q) << FOLD_SHIFT;
  localparam logic [23:0] K2  = K << 1;
  localparam logic [11:0] Q12 = 12'(Q);

  logic             s1_valid;
  logic             s2_valid;
  logic [23:0]      p1;
  logic [OUT_W-1:0] d2;
  logic [OUT_W-1:0] fold_val;
  logic             s2_take;
  logic             s1_take;

  // Each stage frees up when it is empty or when its item moves on this cycle
  always_comb begin
    s2_take  = !s2_valid || out_ready;
    s1_take  = !s1_valid || s2_take;
    in_ready = s1_take;
  end

  // Subtract the largest of 2K, K or 0 that does not exceed the product
  always_comb begin
    fold_val = OUT_W'(p1);
    if (p1 >= K2) begin
      fold_val = OUT_W'(p1 - K2);
    end else if (p1 >= K) begin
      fold_val = OUT_W'(p1 - K);
    end
  end

  // Pipeline registers: a stage loads only when it can pass its current item on
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      p1       <= '0;
      d2       <= '0;
    end else begin
      if (s1_take) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          p1 <= {12'd0, a} * {12'd0, b};
        end
      end
      if (s2_take) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          d2 <= fold_val;
        end
      end
    end
  end

  assign out_valid = s2_valid;
  assign dout      = d2;

`ifdef MOD_MUL_RANGE_CHECK_EN
  logic in_err;
  logic s1_err;
  logic s2_err;
  logic sticky_q;

  assign in_err = (a >= Q12) || (b >= Q12);

  // The range flag moves through the pipeline with its item. The sticky bit latches any flagged accept
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_err   <= 1'b0;
      s2_err   <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      if (s1_take && in_valid) begin
        s1_err <= in_err;
        if (in_err) begin
          sticky_q <= 1'b1;
        end
      end
      if (s2_take && s1_valid) begin
        s2_err <= s1_err;
      end
    end
  end

  assign err        = s2_valid && s2_err;
  assign err_sticky = sticky_q;
`endif

endmodule
